// File: rtl/chroma_pkg.sv
// Shared types and helpers for the chroma threshold calibrator:
// pixel width, calibration FSM states and the threshold clamp function.
package chroma_pkg;

  localparam int PIX_W = 10;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SOF,
    ACCUM,
    DIVIDE,
    UPDATE
  } cal_state_e;

  // Signed subtract so a mean below the margin cannot wrap to a large threshold.
  function automatic logic [PIX_W-1:0] sat_sub_clamp(input logic [PIX_W-1:0] q,
                                                     input int               margin,
                                                     input int               floor);
    int diff;
    diff = int'(q) - margin;
    if (diff < floor) diff = floor;
    return diff[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/chroma_cal_divider.sv
// Restoring unsigned serial divider: one quotient bit per cycle, done pulses
// DIVIDEND_W cycles after start is accepted.
module chroma_cal_divider #(
  parameter int DIVIDEND_W = 34,
  parameter int DIVISOR_W  = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient
);

  localparam int STEP_W = $clog2(DIVIDEND_W + 1);

  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [STEP_W-1:0]     step_q, step_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DIVISOR_W:0]    partial;
  logic [DIVISOR_W:0]    trial;

  always_comb begin
    // NOTE: every _d gets a default before any branch, so no path infers a latch.
    rem_d   = rem_q;
    quo_d   = quo_q;
    step_d  = step_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    partial = {rem_q, quo_q[DIVIDEND_W-1]};
    trial   = partial - {1'b0, divisor};

    if (start && !busy_q) begin
      rem_d  = '0;
      quo_d  = dividend;
      step_d = STEP_W'(DIVIDEND_W);
      busy_d = 1'b1;
    end else if (busy_q) begin
      // trial MSB set means the subtraction borrowed: restore and shift in 0.
      quo_d  = {quo_q[DIVIDEND_W-2:0], ~trial[DIVISOR_W]};
      rem_d  = trial[DIVISOR_W] ? partial[DIVISOR_W-1:0] : trial[DIVISOR_W-1:0];
      step_d = step_q - 1'b1;
      if (step_q == STEP_W'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state is written only with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q  <= '0;
      quo_q  <= '0;
      step_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      step_q <= step_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/chroma_threshold_calibrator.sv
// Measures the mean green level of green-dominant pixels over CAL_FRAMES frames
// and publishes thG = max(mean - MARGIN, MIN_TH). CHROMA_CAL_AUTORUN_EN repeats runs forever.
module chroma_threshold_calibrator
  import chroma_pkg::*;
#(
  parameter int CAL_FRAMES = 2,
  parameter int MARGIN     = 64,
  parameter int MIN_TH     = 32,
  parameter int DEFAULT_TH = 512,
  parameter int CNT_W      = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PIX_W-1:0] video_R,
  input  logic [PIX_W-1:0] video_G,
  input  logic [PIX_W-1:0] video_B,
  input  logic             pixel_valid,
  input  logic             sof,
  input  logic             cal_start,
  output logic [PIX_W-1:0] thG,
  output logic             busy,
  output logic             cal_done,
  output logic             cal_err
);

  localparam int SUM_W = CNT_W + PIX_W;

  cal_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [3:0]       frame_q, frame_d;
  logic             issued_q, issued_d;
  logic             err_q, err_d;
  logic [PIX_W-1:0] quot_q, quot_d;
  logic [PIX_W-1:0] thg_q, thg_d;
  logic             done_q, done_d;
  logic             cal_err_q, cal_err_d;

  logic             qualify;
  logic             sof_hit;
  logic [CNT_W-1:0] acc_cnt;
  logic [SUM_W-1:0] acc_sum;
  logic             div_start;
  logic             div_busy;
  logic             div_done;
  logic [SUM_W-1:0] div_quotient;
  logic             unused_quot_hi;

  assign qualify        = pixel_valid && (video_G > video_R) && (video_G > video_B);
  assign sof_hit        = pixel_valid && sof;
  assign unused_quot_hi = |div_quotient[SUM_W-1:PIX_W];

  // A saturated count freezes both count and sum so the mean stays meaningful.
  always_comb begin
    acc_cnt = cnt_q;
    acc_sum = sum_q;
    if (qualify && (cnt_q != '1)) begin
      acc_cnt = cnt_q + 1'b1;
      acc_sum = sum_q + SUM_W'(video_G);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    frame_d   = frame_q;
    issued_d  = issued_q;
    err_d     = err_q;
    quot_d    = quot_q;
    thg_d     = thg_q;
    done_d    = 1'b0;
    cal_err_d = cal_err_q;
    div_start = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cal_start) begin
          cnt_d     = '0;
          sum_d     = '0;
          frame_d   = '0;
          cal_err_d = 1'b0;
          state_d   = WAIT_SOF;
        end
      end
      WAIT_SOF: begin
        if (sof_hit) begin
          frame_d = 4'd1;
          cnt_d   = acc_cnt;
          sum_d   = acc_sum;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (sof_hit && (frame_q == 4'(CAL_FRAMES))) begin
          state_d  = DIVIDE;
          issued_d = 1'b0;
        end else begin
          cnt_d = acc_cnt;
          sum_d = acc_sum;
          if (sof_hit) frame_d = frame_q + 1'b1;
        end
      end
      DIVIDE: begin
        if (cnt_q == '0) begin
          err_d   = 1'b1;
          state_d = UPDATE;
        end else if (!issued_q && !div_busy) begin
          div_start = 1'b1;
          issued_d  = 1'b1;
        end else if (issued_q && div_done) begin
          err_d    = 1'b0;
          quot_d   = div_quotient[PIX_W-1:0];
          issued_d = 1'b0;
          state_d  = UPDATE;
        end
      end
      UPDATE: begin
        done_d    = 1'b1;
        cal_err_d = err_q;
        if (!err_q) thg_d = sat_sub_clamp(quot_q, MARGIN, MIN_TH);
`ifdef CHROMA_CAL_AUTORUN_EN
        cnt_d   = '0;
        sum_d   = '0;
        frame_d = '0;
        state_d = WAIT_SOF;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sum_q     <= '0;
      frame_q   <= '0;
      issued_q  <= 1'b0;
      err_q     <= 1'b0;
      quot_q    <= '0;
      thg_q     <= PIX_W'(DEFAULT_TH);
      done_q    <= 1'b0;
      cal_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      frame_q   <= frame_d;
      issued_q  <= issued_d;
      err_q     <= err_d;
      quot_q    <= quot_d;
      thg_q     <= thg_d;
      done_q    <= done_d;
      cal_err_q <= cal_err_d;
    end
  end

  chroma_cal_divider #(
    .DIVIDEND_W(SUM_W),
    .DIVISOR_W (CNT_W)
  ) u_divider (
    .clk     (clk),
    .reset   (reset),
    .start   (div_start),
    .dividend(sum_q),
    .divisor (cnt_q),
    .busy    (div_busy),
    .done    (div_done),
    .quotient(div_quotient)
  );

  assign thG      = thg_q;
  assign busy     = (state_q != IDLE);
  assign cal_done = done_q;
  assign cal_err  = cal_err_q;

endmodule
